rsa_modexp_core: RTL and testbench
==================================

RSA_MODEXP_CORE -- requirements
Module: rsa_modexp_core

Interface
REQ-001 SHALL have parameter WIDTH, default 128, giving the operand width of base, exponent, modulus and result (legal range 4..1024).
REQ-002 SHALL have the following ports (clock and reset first):
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  request strobe.
- in_ready  output  1  core can accept a request.
- base  input  WIDTH  message or ciphertext.
- exponent  input  WIDTH  public or private exponent.
- modulus  input  WIDTH  n = p*q.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  base^exponent mod modulus.
- err  output  1  request rejected; qualified by out_valid.
- busy  output  1  state is not IDLE.

Function
REQ-003 SHALL implement states IDLE, SQR, MUL and DONE.
REQ-004 SHALL drive in_ready=1 only in IDLE; a request is accepted on the edge where in_valid=1 and in_ready=1.
REQ-005 SHALL register base, exponent and modulus on acceptance; later input changes SHALL NOT affect the operation.
REQ-006 SHALL reject a request when modulus<2 or base>=modulus: it goes IDLE->DONE on the accepting edge, with result=0 and err=1.
REQ-007 For a valid request, the accepting edge SHALL set acc=1, bit index=WIDTH-1, err=0 and state=SQR.
REQ-008 SQR SHALL compute acc=acc*acc mod modulus over exactly WIDTH cycles.
REQ-009 At the end of SQR, state SHALL go to MUL if exponent[index]=1; otherwise it SHALL decrement index, or go to DONE when index=0.
REQ-010 MUL SHALL compute acc=acc*base mod modulus over exactly WIDTH cycles, then decrement index and return to SQR, or go to DONE when index=0.
REQ-011 Modular multiply SHALL be interleaved shift-add, one multiplier bit per cycle, MSB first:
- R=2R; if the bit is 1, R=R+b.
- Then subtract modulus at most twice so that R<modulus.
- The accumulator SHALL be WIDTH+2 bits; no intermediate result SHALL overflow.
REQ-012 Latency SHALL be exactly WIDTH*(WIDTH+popcount(exponent)) edges from the accepting edge to the edge that sets out_valid=1.
REQ-013 Exponent=0 with a valid modulus SHALL yield result=1 after WIDTH*WIDTH edges.
REQ-014 In DONE, out_valid=1 and result/err SHALL hold stable until out_ready=1; on that edge state SHALL go to IDLE and out_valid to 0.
REQ-015 A new request SHALL NOT be accepted on the same edge as the DONE->IDLE handshake; in_ready rises one edge later.
REQ-016 in_valid while busy SHALL be ignored; no queueing.
REQ-017 result SHALL be the registered acc and SHALL be updated only on entry to DONE.
REQ-018 busy SHALL be 1 in SQR, MUL and DONE.

Reset
REQ-019 reset_n=0 at a rising edge SHALL force: state=IDLE, in_ready=1, out_valid=0, busy=0, err=0, result=0, acc=0, index=0.
REQ-020 Reset SHALL take priority over all handshakes, including mid-SQR or mid-MUL; an aborted operation SHALL produce no out_valid.
REQ-021 No output SHALL change asynchronously with reset_n.

Structure
REQ-022 A shared package rsa_pkg SHALL hold:
- the state enum (IDLE, SQR, MUL, DONE);
- the WIDTH default constant;
- the modmul step count constant.
REQ-023 The modular multiply SHALL be a sub-module rsa_modmul with:
- start/done handshake, parameter WIDTH;
- inputs a, b, m; output p;
- fixed latency of WIDTH cycles.
REQ-024 rsa_modexp_core SHALL contain only the exponent sequencer, the handshake and the operand registers.

Verification
REQ-025 WIDTH=16, base=4, exponent=13, modulus=497 -> result=445, err=0, out_valid 304 edges after accept.
REQ-026 WIDTH=16, encrypt base=65, exponent=17, modulus=3233 -> 2790 after 288 edges; feeding 2790 back with exponent=2753 -> 65 after 336 edges.
REQ-027 WIDTH=16, modulus=1, or base=500 with modulus=497 -> err=1, result=0, out_valid 1 edge after accept.
REQ-028 WIDTH=16, base=7, exponent=0, modulus=11 -> result=1 after 256 edges; with out_ready held 0 for 20 cycles, result stays 1 and in_ready stays 0.
REQ-029 reset_n=0 for one edge mid-MUL of the REQ-025 run -> next edge shows state IDLE, in_ready=1, out_valid=0; a re-issued request still gives 445.
REQ-030 WIDTH=128, the first 128-bit test-vector pair (p=113680897410347, q=7999808077935876437321) with e=65537 and its d -> encrypt then decrypt round trip returns the original message.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation core.
// Holds the sequencer state encoding and the default operand width.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int RSA_WIDTH_DEFAULT = 128;

  // One multiplier bit is consumed per cycle, so a modmul takes WIDTH steps.
  localparam int MODMUL_STEPS = RSA_WIDTH_DEFAULT;

  function automatic int modmul_steps(input int width);
    return width;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = a*b mod m, MSB of a first,
// one bit per cycle, exactly WIDTH cycles from start to done.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int STEPS = modmul_steps(WIDTH);
  localparam int CW    = $clog2(STEPS);

  typedef logic [WIDTH+1:0] acc_t;

  // R < 3m after the shift-add, so two conditional subtractions always suffice.
  function automatic logic [WIDTH-1:0] reduce2(input acc_t x, input logic [WIDTH-1:0] mod);
    acc_t y;
    y = x;
    if (y >= {2'b00, mod}) y = y - {2'b00, mod};
    if (y >= {2'b00, mod}) y = y - {2'b00, mod};
    return y[WIDTH-1:0];
  endfunction

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r, a_sh, b_r, m_r;
  logic [WIDTH-1:0] r_cur, b_cur, m_cur, r_nxt;
  logic             bit_cur;
  acc_t             sum;

  // The start cycle performs step 0 straight from the ports.
  always_comb begin
    r_cur   = start ? '0 : r;
    bit_cur = start ? a[WIDTH-1] : a_sh[WIDTH-1];
    b_cur   = start ? b : b_r;
    m_cur   = start ? m : m_r;
    sum     = {1'b0, r_cur, 1'b0} + (bit_cur ? {2'b00, b_cur} : '0);
    r_nxt   = reduce2(sum, m_cur);
  end

  assign done = run && (cnt == CW'(STEPS - 1));
  assign p    = r_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(1);
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      a_sh <= {a[WIDTH-2:0], 1'b0};
      b_r  <= b;
      m_r  <= m;
      r    <= r_nxt;
    end else if (run) begin
      a_sh <= {a_sh[WIDTH-2:0], 1'b0};
      r    <= r_nxt;
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply sequencer computing base^exponent mod modulus
// with a valid/ready request side and a valid/ready result side.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] base_r, exp_r, mod_r;
  logic [WIDTH-1:0] acc, acc_nxt, result_r, result_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             err_r, err_nxt;
  logic             mm_start, start_nxt, ld_ops;
  logic             mm_done;
  logic [WIDTH-1:0] mm_b, mm_p;

  assign mm_b = (state == MUL) ? base_r : acc;

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mm_start),
    .a       (acc),
    .b       (mm_b),
    .m       (mod_r),
    .done    (mm_done),
    .p       (mm_p)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign err       = err_r;

  always_comb begin
    state_nxt  = state;
    start_nxt  = 1'b0;
    idx_nxt    = idx;
    acc_nxt    = acc;
    err_nxt    = err_r;
    result_nxt = result_r;
    ld_ops     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ld_ops = 1'b1;
          if (modulus < WIDTH'(2) || base >= modulus) begin
            state_nxt  = DONE;
            err_nxt    = 1'b1;
            result_nxt = '0;
          end else begin
            state_nxt = SQR;
            acc_nxt   = WIDTH'(1);
            idx_nxt   = IW'(WIDTH - 1);
            err_nxt   = 1'b0;
            start_nxt = 1'b1;
          end
        end
      end
      SQR: begin
        if (mm_done) begin
          acc_nxt = mm_p;
          if (exp_r[idx]) begin
            state_nxt = MUL;
            start_nxt = 1'b1;
          end else if (idx == '0) begin
            state_nxt  = DONE;
            result_nxt = mm_p;
          end else begin
            idx_nxt   = idx - 1'b1;
            start_nxt = 1'b1;
          end
        end
      end
      MUL: begin
        if (mm_done) begin
          acc_nxt = mm_p;
          if (idx == '0) begin
            state_nxt  = DONE;
            result_nxt = mm_p;
          end else begin
            state_nxt = SQR;
            idx_nxt   = idx - 1'b1;
            start_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      mm_start <= 1'b0;
      idx      <= '0;
      acc      <= '0;
      err_r    <= 1'b0;
      result_r <= '0;
    end else begin
      state    <= state_nxt;
      mm_start <= start_nxt;
      idx      <= idx_nxt;
      acc      <= acc_nxt;
      err_r    <= err_nxt;
      result_r <= result_nxt;
    end
  end

  // Operands are captured once at acceptance and held for the whole run.
  always_ff @(posedge clk) begin
    if (ld_ops) begin
      base_r <= base;
      exp_r  <= exponent;
      mod_r  <= modulus;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed vectors plus random operands, checked
// against an arithmetic modexp reference with latency from the cycle formula.
module tb_rsa_modexp_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        iv16, ir16, ov16, or16, err16, busy16;
  logic [15:0] b16, e16, m16, r16;

  logic         iv128, ir128, ov128, or128, err128, busy128;
  logic [127:0] b128, e128, m128, r128;

  int checks = 0;
  int errors = 0;

  rsa_modexp_core #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .base(b16), .exponent(e16), .modulus(m16), .out_valid(ov16),
    .out_ready(or16), .result(r16), .err(err16), .busy(busy16)
  );

  rsa_modexp_core #(.WIDTH(128)) dut128 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv128), .in_ready(ir128),
    .base(b128), .exponent(e128), .modulus(m128), .out_valid(ov128),
    .out_ready(or128), .result(r128), .err(err128), .busy(busy128)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Right-to-left binary exponentiation on wide integers.
  function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [255:0] r, x, ee;
    r = 256'd1 % m; x = b % m; ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * x) % m;
      x  = (x * x) % m;
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic logic [255:0] modinv(input logic [255:0] a, input logic [255:0] n);
    logic [255:0] t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = n; nr = a;
    while (nr != 0) begin
      q   = r / nr;
      tmp = (t + n - (q * nt) % n) % n;
      t   = nt; nt = tmp;
      tmp = r - q * nr;
      r   = nr; nr = tmp;
    end
    return t;
  endfunction

  task automatic req16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                       input string tag, input int hold, input bit chain,
                       input logic [15:0] nb, input logic [15:0] ne, input logic [15:0] nm);
    logic [255:0] expv;
    logic         experr;
    int           explat, n;
    experr = (m < 16'd2) || (b >= m);
    expv   = experr ? 256'd0 : modexp(b, e, m);
    explat = experr ? 0 : 16 * (16 + $countones(e));
    @(negedge clk);
    n = 0;
    while (!ir16 && n < 2000) begin @(negedge clk); n++; end
    chk({tag, " in_ready"}, ir16, 1);
    iv16 = 1'b1; b16 = b; e16 = e; m16 = m;
    @(posedge clk); #1;
    iv16 = 1'b0; b16 = 16'($urandom); e16 = 16'($urandom); m16 = 16'($urandom);
    n = 0;
    while (!ov16 && n < 16 * 33) begin @(posedge clk); #1; n++; end
    chk({tag, " out_valid"}, ov16, 1);
    chk({tag, " latency"}, n, explat);
    chk({tag, " result"}, r16, expv);
    chk({tag, " err"}, err16, experr);
    chk({tag, " busy"}, busy16, 1);
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) iv16 = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold result"}, r16, expv);
      chk({tag, " hold in_ready"}, ir16, 0);
      chk({tag, " hold out_valid"}, ov16, 1);
    end
    iv16 = chain;
    if (chain) begin b16 = nb; e16 = ne; m16 = nm; end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk({tag, " release out_valid"}, ov16, 0);
    chk({tag, " release in_ready"}, ir16, 1);
    chk({tag, " release busy"}, busy16, 0);
  endtask

  task automatic req128(input logic [127:0] b, input logic [127:0] e, input logic [127:0] m,
                        input string tag, output logic [127:0] res);
    logic [255:0] expv;
    int           explat, n;
    expv   = modexp(b, e, m);
    explat = 128 * (128 + $countones(e));
    @(negedge clk);
    n = 0;
    while (!ir128 && n < 2000) begin @(negedge clk); n++; end
    chk({tag, " in_ready"}, ir128, 1);
    iv128 = 1'b1; b128 = b; e128 = e; m128 = m;
    @(posedge clk); #1;
    iv128 = 1'b0; b128 = '0; e128 = '0; m128 = '0;
    n = 0;
    while (!ov128 && n < 128 * 257 + 10) begin @(posedge clk); #1; n++; end
    chk({tag, " out_valid"}, ov128, 1);
    chk({tag, " latency"}, n, explat);
    chk({tag, " result"}, r128, expv);
    chk({tag, " err"}, err128, 0);
    res = r128;
    or128 = 1'b1;
    @(posedge clk); #1;
    or128 = 1'b0;
    chk({tag, " release out_valid"}, ov128, 0);
  endtask

  initial begin
    logic [15:0]  rb, re, rm;
    logic [255:0] p, q, n, phi, d, msg;
    logic [127:0] c, back;
    int           seen;

    reset_n = 1'b0;
    iv16 = 0; or16 = 0; b16 = 0; e16 = 0; m16 = 0;
    iv128 = 0; or128 = 0; b128 = 0; e128 = 0; m128 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", ir16, 1);
    chk("rst out_valid", ov16, 0);
    chk("rst busy", busy16, 0);
    chk("rst err", err16, 0);
    chk("rst result", r16, 0);
    chk("rst128 in_ready", ir128, 1);
    chk("rst128 busy", busy128, 0);
    @(negedge clk);
    reset_n = 1'b1;

    req16(16'd4, 16'd13, 16'd497, "v497", 0, 0, 0, 0, 0);
    req16(16'd65, 16'd17, 16'd3233, "enc", 0, 1, 16'd2790, 16'd2753, 16'd3233);
    req16(16'd2790, 16'd2753, 16'd3233, "dec", 0, 0, 0, 0, 0);
    req16(16'd0, 16'd5, 16'd1, "mod1", 0, 0, 0, 0, 0);
    req16(16'd500, 16'd3, 16'd497, "b_ge_m", 0, 0, 0, 0, 0);
    req16(16'd7, 16'd0, 16'd11, "exp0", 20, 0, 0, 0, 0);

    // Reset lands in the middle of the first MUL of 4^13 mod 497.
    @(negedge clk);
    iv16 = 1'b1; b16 = 16'd4; e16 = 16'd13; m16 = 16'd497;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (13 * 16 + 8) @(posedge clk);
    #1;
    chk("abort pre busy", busy16, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort in_ready", ir16, 1);
    chk("abort out_valid", ov16, 0);
    chk("abort busy", busy16, 0);
    chk("abort result", r16, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (ov16) seen++;
    end
    chk("abort no out_valid", seen, 0);
    req16(16'd4, 16'd13, 16'd497, "reissue", 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      rm = 16'($urandom_range(2, 65535));
      rb = 16'($urandom_range(0, 32'(rm) - 1));
      re = 16'($urandom);
      req16(rb, re, rm, "rand", 0, 0, 0, 0, 0);
    end
    rm = 16'($urandom_range(2, 65535));
    rb = 16'($urandom_range(32'(rm), 65535));
    req16(rb, 16'($urandom), rm, "rand_rej", 0, 0, 0, 0, 0);

    p   = 256'd113680897410347;
    q   = 256'd7999808077935876437321;
    n   = p * q;
    phi = (p - 1) * (q - 1);
    d   = modinv(256'd65537, phi);
    msg = {$urandom, $urandom, $urandom, $urandom};
    msg = msg % n;
    req128(msg[127:0], 128'd65537, n[127:0], "enc128", c);
    req128(c, d[127:0], n[127:0], "dec128", back);
    chk("roundtrip128", back, msg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
